// File: rtl/fnd_pkg.sv
// Shared definitions for the BCD seven-segment display path: common-anode
// glyph constants, the nibble-to-glyph decoder and the converter state type.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_e;

  // Non-decimal nibbles cannot come out of the converter; show them blank.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] nibble);
    logic [7:0] pat_s;
    case (nibble)
      4'd0:    pat_s = SEG_0;
      4'd1:    pat_s = SEG_1;
      4'd2:    pat_s = SEG_2;
      4'd3:    pat_s = SEG_3;
      4'd4:    pat_s = SEG_4;
      4'd5:    pat_s = SEG_5;
      4'd6:    pat_s = SEG_6;
      4'd7:    pat_s = SEG_7;
      4'd8:    pat_s = SEG_8;
      4'd9:    pat_s = SEG_9;
      default: pat_s = SEG_BLANK;
    endcase
    return pat_s;
  endfunction

  // Largest value representable in the given number of decimal digits.
  function automatic logic [31:0] bcd_limit(input int digits);
    logic [31:0] acc_s;
    acc_s = 32'd1;
    for (int i = 0; i < digits; i++) begin
      acc_s = acc_s * 32'd10;
    end
    return acc_s - 32'd1;
  endfunction

endpackage

// File: rtl/fnd_bcd_scanner_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with a
// valid/ready input handshake, overflow flag and a one-cycle done pulse.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ovf,
  output logic                  done
);

  localparam int          BW        = DIGITS * 4;
  localparam logic [31:0] MAX_VAL_C = bcd_limit(DIGITS);

  conv_state_e      state_r, state_next_s;
  logic [WIDTH-1:0] bin_r, bin_next_s;
  logic [BW-1:0]    acc_r, acc_next_s, adj_s, shifted_s;
  logic [BW-1:0]    bcd_r, bcd_next_s;
  logic [5:0]       cnt_r, cnt_next_s;
  logic             ovf_pend_r, ovf_pend_next_s;
  logic             ovf_r, ovf_next_s;
  logic             done_r, done_next_s;
  logic             ready_r, ready_next_s;
  logic [31:0]      in_ext_s;

  assign in_ext_s = 32'(in_data);

  // Add-3 correction on every nibble of 5 or more, then shift in the next binary bit.
  always_comb begin
    adj_s = acc_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = acc_r[4*i +: 4];
      end
    end
    shifted_s = {adj_s[BW-2:0], bin_r[WIDTH-1]};
  end

  // Converter FSM: accept in IDLE, shift WIDTH times, commit on the last shift.
  always_comb begin
    state_next_s    = state_r;
    bin_next_s      = bin_r;
    acc_next_s      = acc_r;
    cnt_next_s      = cnt_r;
    ovf_pend_next_s = ovf_pend_r;
    bcd_next_s      = bcd_r;
    ovf_next_s      = ovf_r;
    done_next_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s    = SHIFT;
          bin_next_s      = in_data;
          acc_next_s      = {BW{1'b0}};
          cnt_next_s      = 6'd0;
          ovf_pend_next_s = (in_ext_s > MAX_VAL_C);
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        acc_next_s = shifted_s;
        bin_next_s = bin_r << 1;
        cnt_next_s = cnt_r + 6'd1;
        if (cnt_r == 6'(WIDTH - 1)) begin
          state_next_s = IDLE;
          bcd_next_s   = shifted_s;
          ovf_next_s   = ovf_pend_r;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = SHIFT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    ready_next_s = (state_next_s == IDLE);
  end

  // Converter state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      bin_r      <= {WIDTH{1'b0}};
      acc_r      <= {BW{1'b0}};
      cnt_r      <= 6'd0;
      ovf_pend_r <= 1'b0;
      bcd_r      <= {BW{1'b0}};
      ovf_r      <= 1'b0;
      done_r     <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      bin_r      <= bin_next_s;
      acc_r      <= acc_next_s;
      cnt_r      <= cnt_next_s;
      ovf_pend_r <= ovf_pend_next_s;
      bcd_r      <= bcd_next_s;
      ovf_r      <= ovf_next_s;
      done_r     <= done_next_s;
      ready_r    <= ready_next_s;
    end
  end

  assign in_ready = ready_r;
  assign bcd      = bcd_r;
  assign ovf      = ovf_r;
  assign done     = done_r;

endmodule

// File: rtl/fnd_bcd_scanner.sv
// Binary value to multiplexed common-anode seven-segment display.
// Optional build macro FND_LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero digit (digit 0 always shows a glyph).
module fnd_bcd_scanner
  import fnd_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4,
  parameter int DIV    = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              done,
  output logic              ovf,
  output logic [DIGITS-1:0] seg_comm,
  output logic [7:0]        seg
);

  localparam int              DW           = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int              IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] COMM_RESET_C = ~(DIGITS'(1));

  logic [DIGITS*4-1:0] bcd_s;
  logic                ovf_s;
  logic [DW-1:0]       ref_cnt_r;
  logic                wrap_s;
  logic [IW-1:0]       idx_r, idx_next_s;
  logic [DIGITS-1:0]   comm_next_s, seg_comm_r, blank_s;
  logic [3:0]          nib_s;
  logic [7:0]          seg_next_s, seg_r;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd      (bcd_s),
    .ovf      (ovf_s),
    .done     (done)
  );

  assign ovf = ovf_s;

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic zero_above_s;

  // A digit is blank when it and every digit above it are zero (never digit 0).
  always_comb begin
    zero_above_s = 1'b1;
    blank_s      = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (bcd_s[4*i +: 4] == 4'd0);
      blank_s[i]   = (i != 0) && zero_above_s;
    end
  end
`else
  assign blank_s = {DIGITS{1'b0}};
`endif

  // Next digit index and the glyph/enable pair for it, so both update together.
  always_comb begin
    wrap_s = (ref_cnt_r == DW'(DIV - 1));
    if (!wrap_s) begin
      idx_next_s = idx_r;
    end else if (idx_r == IW'(DIGITS - 1)) begin
      idx_next_s = {IW{1'b0}};
    end else begin
      idx_next_s = idx_r + IW'(1);
    end
    comm_next_s              = {DIGITS{1'b1}};
    comm_next_s[idx_next_s]  = 1'b0;
    nib_s                    = bcd_s[{idx_next_s, 2'b00} +: 4];
    if (ovf_s) begin
      seg_next_s = SEG_DASH;
    end else if (blank_s[idx_next_s]) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = bcd_to_seg(nib_s);
    end
  end

  // Refresh counter, digit index and the registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_r  <= {DW{1'b0}};
      idx_r      <= {IW{1'b0}};
      seg_comm_r <= COMM_RESET_C;
      seg_r      <= SEG_0;
    end else begin
      ref_cnt_r  <= wrap_s ? {DW{1'b0}} : ref_cnt_r + DW'(1);
      idx_r      <= idx_next_s;
      seg_comm_r <= comm_next_s;
      seg_r      <= seg_next_s;
    end
  end

  assign seg_comm = seg_comm_r;
  assign seg      = seg_r;

endmodule

// File: tb/tb_fnd_bcd_scanner.sv
// Scoreboard bench for fnd_bcd_scanner: stimulus pushes accepted values,
// a negedge monitor predicts handshake/scan timing and decodes digits arithmetically.
`timescale 1ns/1ps
module tb_fnd_bcd_scanner;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic [WIDTH-1:0]  in_data  = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, done, ovf;
  logic [DIGITS-1:0] seg_comm;
  logic [7:0]        seg;

  int checks = 0;
  int fails  = 0;

  int unsigned sb_q[$];

  logic        reset_prev = 1'b1;
  logic        valid_prev = 1'b0;
  int          busy       = 0;
  int          n_edges    = 0;
  int unsigned disp_val   = 0;

  logic [7:0] glyph_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  fnd_bcd_scanner #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS),
    .DIV    (DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .done     (done),
    .ovf      (ovf),
    .seg_comm (seg_comm),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) begin
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Glyph of decimal digit idx of value v, as it should appear on the pins.
  function automatic logic [7:0] exp_seg(input int unsigned v, input int idx);
    int unsigned p;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (v > 9999) return 8'hBF;
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < p) return 8'hFF;
`endif
    return glyph_tab[(v / p) % 10];
  endfunction

  // Monitor: advance the reference model by one edge and compare all outputs.
  always @(negedge clk) begin : monitor
    int unsigned old_disp;
    logic        exp_done;
    int          idx;
    logic [3:0]  exp_comm;
    old_disp = disp_val;
    if (reset_prev) begin
      n_edges  = 0;
      busy     = 0;
      disp_val = 0;
      old_disp = 0;
      exp_done = 1'b0;
      sb_q.delete();
    end else begin
      n_edges++;
      if (busy > 0) begin
        busy--;
        exp_done = (busy == 0);
      end else begin
        exp_done = 1'b0;
        if (valid_prev) busy = WIDTH;
      end
      if (done === 1'b1) begin
        check("done_has_pending", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) disp_val = sb_q.pop_front();
      end
    end
    idx = (n_edges / DIV) % DIGITS;
    exp_comm = 4'hF;
    exp_comm[idx] = 1'b0;
    check("done", done, exp_done);
    check("in_ready", in_ready, (busy == 0));
    check("ovf", ovf, (disp_val > 9999));
    check("seg_comm", seg_comm, exp_comm);
    check("seg", seg, exp_seg(old_disp, idx));
    reset_prev = reset;
    valid_prev = in_valid;
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Offer v until the converter is ready; record it in the scoreboard on acceptance.
  task automatic wait_accept(input int unsigned v);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        sb_q.push_back(v);
        got = 1'b1;
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: value %0d never accepted", v);
    end
  endtask

  task automatic send(input int unsigned v);
    in_data  = v[WIDTH-1:0];
    in_valid = 1'b1;
    wait_accept(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  initial begin
    int unsigned dir_vals[8] = '{1234, 9999, 10000, 0, 42, 16383, 1, 10};
    int unsigned stream[3]   = '{5, 42, 7};
    int unsigned v;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(24);

    foreach (dir_vals[i]) begin
      send(dir_vals[i]);
      idle(WIDTH + 2 * DIGITS * DIV);
    end

    // Back-to-back stream with in_valid held; data wiggles during conversion.
    in_data  = stream[0][WIDTH-1:0];
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_accept(stream[k]);
      @(posedge clk);
      #1;
      in_data = WIDTH'($urandom);
      if (k == 2) in_valid = 1'b0;
      idle(4);
      if (k < 2) in_data = stream[k+1][WIDTH-1:0];
      else       in_data = WIDTH'($urandom);
    end
    idle(WIDTH + 2 * DIGITS * DIV);

    // Reset during the sixth shift aborts the conversion.
    in_data  = 14'd1234;
    in_valid = 1'b1;
    wait_accept(1234);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(24);
    send(777);
    idle(WIDTH + 2 * DIGITS * DIV);

    // Random values with random gaps, including overflowing ones.
    for (int r = 0; r < 25; r++) begin
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 16383);
      send(v);
      idle($urandom_range(0, 20));
    end
    idle(WIDTH + 2 * DIGITS * DIV);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
